// File: rtl/seq_subtractor_64bit_if.sv
// Start/done handshake bundle for the sequential subtractor.
// The controller side uses master; the subtractor itself uses slave.
interface seq_subtractor_64bit_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             bout;
  logic             ovf;

  modport master (
    output start, A, B, bin,
    input  busy, done, D, bout, ovf
  );

  modport slave (
    input  start, A, B, bin,
    output busy, done, D, bout, ovf
  );
endinterface

// File: rtl/seq_subtractor_64bit.sv
// Multi-cycle subtractor computing D = A - B - bin.
// One SLICE-bit chunk is handled per clock, LSB first, with the borrow rippling between chunks.
module seq_subtractor_64bit #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_subtractor_64bit_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] aSlice;
  logic [SLICE-1:0] bSlice;
  logic [SLICE:0]   sliceDiff;
  int               sliceBase;
  logic             lastSlice;

  assign lastSlice = (idx_q == IDXW'(NSLICE - 1));
  assign sliceBase = int'(idx_q) * SLICE;
  assign aSlice    = a_q[sliceBase +: SLICE];
  assign bSlice    = b_q[sliceBase +: SLICE];
  // The extra top bit of the widened difference is set exactly when the slice underflows.
  assign sliceDiff = {1'b0, aSlice} - {1'b0, bSlice} - {{SLICE{1'b0}}, borrow_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = bus.start ? RUN : IDLE;
      RUN:        if (lastSlice) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.D    = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

  // Published results only move on the completion edge so they survive IDLE and the next run.
  always_comb begin
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d      = bus.A;
          b_d      = bus.B;
          borrow_d = bus.bin;
          idx_d    = '0;
        end
      end
      RUN: begin
        work_d[sliceBase +: SLICE] = sliceDiff[SLICE-1:0];
        borrow_d                   = sliceDiff[SLICE];
        idx_d                      = idx_q + IDXW'(1);
        if (lastSlice) begin
          diff_d = work_d;
          bout_d = sliceDiff[SLICE];
          ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
